// File: rtl/pixel_writer.sv
// pixel_writer: read-modify-write of 4-bit pixels into a 32-bit-word framebuffer
// Ports: clk_25 / rst_n       pixel clock, asynchronous active-low reset
//        wr_valid / wr_ready  pixel command handshake, payload wr_x, wr_y, wr_color
//        mem_*                framebuffer word port, mem_rdata valid one cycle after mem_re
//        mem_row              display reader owns the framebuffer, no strobes allowed
//        clear_req, clr_color full-frame clear request and fill colour
//        busy, drop_cnt       activity flag, saturating count of out-of-range commands
// Build option: PIXEL_WRITER_CLEAR_EN enables the full-frame clear engine.
module pixel_writer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [3:0]  wr_color,
  input  logic        mem_row,
  output logic [8:0]  mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        clear_req,
  input  logic [3:0]  clr_color,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [8:0] LAST_WORD = 9'd383;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_MOD, S_WR, S_CLR} state_t;
  state_t state_q, state_d;
  logic [15:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [31:0] word_q, word_d;
  logic [8:0] clr_addr_q, clr_addr_d;
  logic clr_pend_q, clr_pend_d;
  logic [3:0] clr_color_q, clr_color_d;
  logic [7:0] drop_q, drop_d;
  logic accept, push, pop, has_cmd, row_free;
  logic [15:0] head;
  logic [8:0] head_addr;
  logic [4:0] sh;
  // FIFO entry layout: {x[5:0], y[5:0], color[3:0]}
  assign row_free = !mem_row;
  assign wr_ready = rst_n && count_q != FULL && !clr_pend_q && state_q != S_CLR;
  assign accept = wr_valid && wr_ready;
  assign push = accept && wr_y < 6'd48;
  assign pop = state_q == S_WR && row_free;
  // Looking at the incoming push lets an empty FIFO start its read the cycle after acceptance
  assign has_cmd = count_q != '0 || push;
  assign head = fifo_mem[rptr_q];
  assign head_addr = {head[9:4], head[15:13]};
  assign sh = {head[12:10], 2'b00};
  assign drop_cnt = drop_q;
  always_ff @(posedge clk_25)
    if (push) fifo_mem[wptr_q] <= {wr_x, wr_y, wr_color};
  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    word_d = state_q == S_MOD && row_free ? (mem_rdata & ~(32'hF << sh)) | ({28'd0, head[3:0]} << sh) : word_q;
    clr_addr_d = state_q == S_CLR && row_free ? (clr_addr_q == LAST_WORD ? 9'd0 : clr_addr_q + 9'd1) : clr_addr_q;
    drop_d = accept && !push && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
  end
`ifdef PIXEL_WRITER_CLEAR_EN
  // A pending clear is consumed by the idle state, which always hands it to S_CLR
  always_comb begin
    clr_pend_d = clear_req || (clr_pend_q && state_q != S_IDLE);
    clr_color_d = clear_req ? clr_color : clr_color_q;
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clear_req, clr_color};
  assign clr_pend_d = 1'b0;
  assign clr_color_d = 4'd0;
`endif
  always_ff @(posedge clk_25 or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      word_q <= '0;
      clr_addr_q <= '0;
      clr_pend_q <= 1'b0;
      clr_color_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      word_q <= word_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
      clr_color_q <= clr_color_d;
      drop_q <= drop_d;
    end
  // Losing the memory mid-command always restarts from the read so the merge sees fresh data
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = clr_pend_q ? S_CLR : has_cmd && row_free ? S_RD : S_IDLE;
      S_RD: state_d = row_free ? S_MOD : S_RD;
      S_MOD: state_d = row_free ? S_WR : S_RD;
      S_WR: state_d = row_free ? S_IDLE : S_RD;
      S_CLR: state_d = row_free && clr_addr_q == LAST_WORD ? S_IDLE : S_CLR;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    mem_re = state_q == S_RD && row_free;
    mem_we = (state_q == S_WR || state_q == S_CLR) && row_free;
    mem_addr = state_q == S_CLR && row_free ? clr_addr_q : mem_re || mem_we ? head_addr : 9'd0;
    mem_wdata = !mem_we ? 32'd0 : state_q == S_CLR ? {8{clr_color_q}} : word_q;
    busy = count_q != '0 || state_q != S_IDLE || clr_pend_q;
  end
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed checks of pixel_writer against a behavioural framebuffer
module tb_pixel_writer;
  logic clk_25 = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, mem_row = 1'b0, clear_req = 1'b0;
  logic [5:0] wr_x = '0, wr_y = '0;
  logic [3:0] wr_color = '0, clr_color = '0;
  logic wr_ready, mem_re, mem_we, busy;
  logic [8:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0] drop_cnt;
  logic [31:0] mem [512];
  int n_tests = 0, n_fail = 0, n_re = 0, n_we = 0, n_viol = 0;
  int r0, w0, errs, idx;
  always #20 clk_25 = ~clk_25;
  pixel_writer dut (
    .clk_25(clk_25), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .mem_row(mem_row),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .clear_req(clear_req), .clr_color(clr_color),
    .busy(busy), .drop_cnt(drop_cnt)
  );
  always @(posedge clk_25) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) n_re <= n_re + 1;
    if (mem_we) n_we <= n_we + 1;
    if ((mem_re || mem_we) && mem_row) n_viol <= n_viol + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk_25);
    #1;
  endtask
  task automatic send(input logic [5:0] x, input logic [5:0] y, input logic [3:0] c);
    logic ok;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_x = x;
    wr_y = y;
    wr_color = c;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = wr_ready;
      step(1);
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) step(1);
    check("idle", 32'(busy), 32'd0);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    step(2);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    step(1);
    check("ready_after_rst", 32'(wr_ready), 32'd1);
    // single read-modify-write with exact cycle timing
    mem[17] = 32'h12345678;
    send(6'd13, 6'd2, 4'hA);
    wr_valid = 1'b0;
    check("rmw_re", 32'(mem_re), 32'd1);
    check("rmw_re_addr", 32'(mem_addr), 32'd17);
    step(1);
    check("rmw_mod_strobes", 32'({mem_re, mem_we}), 32'd0);
    check("rmw_mod_addr", 32'(mem_addr), 32'd0);
    step(1);
    check("rmw_we", 32'(mem_we), 32'd1);
    check("rmw_we_addr", 32'(mem_addr), 32'd17);
    check("rmw_wdata", mem_wdata, 32'h12A45678);
    step(1);
    check("rmw_we_end", 32'(mem_we), 32'd0);
    check("rmw_wdata_end", mem_wdata, 32'd0);
    wait_idle();
    check("rmw_mem", mem[17], 32'h12A45678);
    // back-to-back commands into the same word
    w0 = n_we;
    send(6'd0, 6'd0, 4'h1);
    send(6'd7, 6'd0, 4'h2);
    wr_valid = 1'b0;
    wait_idle();
    check("b2b_mem", mem[0], 32'h20000001);
    check("b2b_writes", 32'(n_we - w0), 32'd2);
    // FIFO fills while the reader owns memory, then drains
    r0 = n_re;
    mem_row = 1'b1;
    send(6'd1, 6'd1, 4'h3);
    send(6'd9, 6'd1, 4'h4);
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    step(3);
    check("full_no_read", 32'(n_re - r0), 32'd0);
    mem_row = 1'b0;
    send(6'd17, 6'd1, 4'h5);
    send(6'd63, 6'd47, 4'hF);
    wr_valid = 1'b0;
    wait_idle();
    check("burst_w8", mem[8], 32'h00000030);
    check("burst_w9", mem[9], 32'h00000040);
    check("burst_w10", mem[10], 32'h00000050);
    check("burst_w383", mem[383], 32'hF0000000);
    // out-of-range commands are counted and never touch memory
    r0 = n_re;
    w0 = n_we;
    send(6'd0, 6'd48, 4'h1);
    wr_valid = 1'b0;
    step(5);
    check("drop_one", 32'(drop_cnt), 32'd1);
    check("drop_no_strobe", 32'((n_re - r0) + (n_we - w0)), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 299; i++) send(6'(i), 6'(48 + i % 16), 4'h2);
    wr_valid = 1'b0;
    step(2);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("drop_sat_no_strobe", 32'((n_re - r0) + (n_we - w0)), 32'd0);
    // reader takes memory during the modify cycle
    mem[20] = 32'hFFFFFFFF;
    r0 = n_re;
    w0 = n_we;
    send(6'd34, 6'd2, 4'h0);
    wr_valid = 1'b0;
    check("row_first_re", 32'(mem_re), 32'd1);
    step(1);
    mem_row = 1'b1;
    #1;
    check("row_mod_quiet", 32'({mem_re, mem_we}), 32'd0);
    step(10);
    mem_row = 1'b0;
    #1;
    check("row_reread", 32'(mem_re), 32'd1);
    check("row_reread_addr", 32'(mem_addr), 32'd20);
    wait_idle();
    check("row_mem", mem[20], 32'hFFFFF0FF);
    check("row_reads", 32'(n_re - r0), 32'd2);
    check("row_writes", 32'(n_we - w0), 32'd1);
    // reset between read and write abandons the command
    mem[21] = 32'd0;
    w0 = n_we;
    send(6'd40, 6'd2, 4'h7);
    wr_valid = 1'b0;
    check("rst_mid_re", 32'(mem_re), 32'd1);
    step(1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", 32'({mem_re, mem_we}), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_wdata", mem_wdata, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(wr_ready), 32'd0);
    check("rst_mid_drop", 32'(drop_cnt), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(10);
    check("rst_mid_no_we", 32'(n_we - w0), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);
    check("rst_mid_mem", mem[21], 32'd0);
    // full-frame clear
    w0 = n_we;
    clear_req = 1'b1;
    clr_color = 4'h5;
    step(1);
    clear_req = 1'b0;
`ifdef PIXEL_WRITER_CLEAR_EN
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_ready", 32'(wr_ready), 32'd0);
    errs = 0;
    idx = 0;
    for (int i = 0; i < 1000 && busy; i++) begin
      if (mem_we) begin
        if (mem_addr !== 9'(idx) || mem_wdata !== 32'h55555555) errs++;
        idx++;
      end else if (idx > 0 && idx < 384) errs++;
      if (wr_ready) errs++;
      step(1);
    end
    check("clr_count", 32'(idx), 32'd384);
    check("clr_errors", 32'(errs), 32'd0);
    check("clr_idle", 32'(busy), 32'd0);
    check("clr_mem17", mem[17], 32'h55555555);
    check("clr_mem383", mem[383], 32'h55555555);
`else
    check("noclr_busy", 32'(busy), 32'd0);
    step(5);
    check("noclr_no_we", 32'(n_we - w0), 32'd0);
    check("noclr_ready", 32'(wr_ready), 32'd1);
`endif
    check("row_violations", 32'(n_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
